// File: rtl/banked_mem_ctrl_pkg.sv
// rtl/banked_mem_ctrl_pkg.sv - shared encodings and helpers for the banked memory controller
package banked_mem_ctrl_pkg;

  localparam logic [1:0] MODE_BYTE = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int lane_bits(input int lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/banked_mem_ctrl_lane_bank.sv
// rtl/banked_mem_ctrl_lane_bank.sv - one byte lane: synchronous single-port RAM with write enable
module lane_bank #(
  parameter int LANE_W = 8,
  parameter int ROW_W  = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ROW_W-1:0]  row,
  input  logic [LANE_W-1:0] wdata,
  output logic [LANE_W-1:0] rdata
);

  logic [LANE_W-1:0] r_mem [1<<ROW_W];
  logic [LANE_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (we) r_mem[row] <= wdata;
    r_q <= r_mem[row];
  end

  assign rdata = r_q;

endmodule

// File: rtl/banked_mem_ctrl.sv
// rtl/banked_mem_ctrl.sv - byte-lane memory controller with wait states, extension and error reporting
module banked_mem_ctrl
  import banked_mem_ctrl_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int LANE_W      = 8,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      rw,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [1:0]                mode,
  input  logic                      sign_ext,
  input  logic [LANES*LANE_W-1:0]   wdata,
  output logic [LANES*LANE_W-1:0]   rdata,
  output logic                      moc,
  output logic                      busy,
  output logic                      err
);

  localparam int LB     = lane_bits(LANES);
  localparam int DATA_W = LANES * LANE_W;
  localparam int ROW_W  = ADDR_W - LB;
  localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rw;
  logic [1:0]          r_mode;
  logic                r_sext;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  logic [LB-1:0]       w_start;
  logic [ROW_W-1:0]    w_row;
  logic [3:0]          w_n;
  logic                w_illegal, w_misal, w_err;
  logic                w_do_write, w_do_read;
  logic [LANES-1:0]    w_we;
  logic [LANE_W-1:0]   w_lane_d [LANES];
  logic [LANE_W-1:0]   w_lane_q [LANES];
  logic [DATA_W-1:0]   w_sel, w_ext;

  assign w_start   = r_addr[LB-1:0];
  assign w_row     = r_addr[ADDR_W-1:LB];
  assign w_n       = 4'd1 << r_mode;
  assign w_illegal = int'(r_mode) > LB;
  assign w_misal   = |(r_addr & (ADDR_W'(w_n) - ADDR_W'(1)));
  assign w_err     = w_illegal | w_misal;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req) w_next = ACCESS;
      ACCESS:  if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // reset gates the DONE-cycle effects so an aborted access neither commits nor completes
  always_comb begin
    busy       = (r_state == ACCESS) || (r_state == DONE);
    moc        = (r_state == DONE) && !reset;
    err        = moc && w_err;
    w_do_write = moc && !w_err && !r_rw;
    w_do_read  = moc && !w_err && r_rw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_mode  <= MODE_BYTE;
      r_sext  <= 1'b0;
      r_wdata <= '0;
    end else if (r_state == IDLE && req) begin
      r_cnt   <= '0;
      r_addr  <= addr;
      r_rw    <= rw;
      r_mode  <= mode;
      r_sext  <= sign_ext;
      r_wdata <= wdata;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // big-endian gather: the lowest selected lane lands in the most significant byte
  always_comb begin : sel_ext
    logic [LB-1:0] idx;
    idx   = '0;
    w_sel = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = w_start + LB'(k);
      if (k < int'(w_n)) w_sel = (w_sel << LANE_W) | DATA_W'(w_lane_q[idx]);
    end
    w_ext = w_sel;
    if (r_sext && int'(w_n) < LANES) begin
      for (int b = 0; b < DATA_W; b++)
        if (b >= int'(w_n) * LANE_W) w_ext[b] = w_sel[int'(w_n) * LANE_W - 1];
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      w_we[j]     = 1'b0;
      w_lane_d[j] = '0;
      if (j >= int'(w_start) && j < int'(w_start) + int'(w_n)) begin
        w_we[j]     = w_do_write;
        w_lane_d[j] = r_wdata[(int'(w_n) - 1 - (j - int'(w_start))) * LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          r_rdata <= '0;
    else if (w_do_read) r_rdata <= w_ext;
  end

  assign rdata = r_rdata;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_bank #(
      .LANE_W (LANE_W),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk   (clk),
      .we    (w_we[g]),
      .row   (w_row),
      .wdata (w_lane_d[g]),
      .rdata (w_lane_q[g])
    );
  end

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// tb/tb_banked_mem_ctrl.sv - directed self-checking bench for banked_mem_ctrl
module tb_banked_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset, req, rw, sign_ext;
  logic [8:0]  addr;
  logic [1:0]  mode;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        moc, busy, err;
  int          checks = 0;
  int          errors = 0;

  banked_mem_ctrl #(
    .LANES(4), .LANE_W(8), .ADDR_W(9), .WAIT_CYCLES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .rw       (rw),
    .addr     (addr),
    .mode     (mode),
    .sign_ext (sign_ext),
    .wdata    (wdata),
    .rdata    (rdata),
    .moc      (moc),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // one request; inputs are scrambled right after the latch edge
  task automatic access(input logic a_rw, input logic [8:0] a_addr, input logic [1:0] a_mode,
                        input logic a_se, input logic [31:0] a_wd, input logic hold,
                        output int lat, output logic e, output logic [31:0] rd,
                        output int mocs, output logic [8:0] bmask);
    lat = -1; e = 1'b0; mocs = 0; bmask = '0;
    @(negedge clk);
    req = 1'b1; rw = a_rw; addr = a_addr; mode = a_mode; sign_ext = a_se; wdata = a_wd;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        rw = ~a_rw; addr = ~a_addr; mode = ~a_mode; sign_ext = ~a_se; wdata = ~a_wd;
      end
      if (!hold || c >= 3) req = 1'b0;
      bmask[c] = busy;
      if (moc) begin
        mocs++;
        if (lat < 0) begin lat = c; e = err; end
      end
    end
    rd = rdata;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want %h", rdata, 32'h0); end
    checks++; if (moc !== 1'b0) begin errors++; $display("FAIL reset_moc got %b want 0", moc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_word_rw;
    int lat, mocs; logic e; logic [31:0] rd; logic [8:0] bm;
    access(1'b0, 9'h010, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL word_write got lat %0d err %b want lat 3 err 0", lat, e); end
    access(1'b1, 9'h010, 2'd2, 1'b0, 32'h0, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read got %h want %h", rd, 32'hDEADBEEF); end
    checks++; if (lat !== 3 || mocs !== 1 || e !== 1'b0) begin errors++; $display("FAIL word_read_moc got lat %0d mocs %0d err %b want 3 1 0", lat, mocs, e); end
    checks++; if (bm !== 9'b0_0000_1110) begin errors++; $display("FAIL word_read_busy got %b want %b", bm, 9'b0_0000_1110); end
  endtask

  task automatic test_byte_half_reads;
    logic [8:0]  ta [5] = '{9'h011, 9'h013, 9'h012, 9'h012, 9'h010};
    logic [1:0]  tm [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    logic        ts [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] tx [5] = '{32'hFFFFFFAD, 32'h000000EF, 32'h0000BEEF, 32'hFFFFBEEF, 32'h0000DEAD};
    int lat, mocs; logic e; logic [31:0] rd; logic [8:0] bm;
    for (int i = 0; i < 5; i++) begin
      access(1'b1, ta[i], tm[i], ts[i], 32'h0, 1'b0, lat, e, rd, mocs, bm);
      checks++;
      if (rd !== tx[i] || e !== 1'b0)
        begin errors++; $display("FAIL sub_read[%0d] got %h err %b want %h err 0", i, rd, e, tx[i]); end
    end
  endtask

  task automatic test_byte_write;
    int lat, mocs; logic e; logic [31:0] rd; logic [8:0] bm;
    access(1'b0, 9'h012, 2'd0, 1'b0, 32'hFFFFFF55, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (e !== 1'b0 || mocs !== 1) begin errors++; $display("FAIL byte_write got err %b mocs %0d want 0 1", e, mocs); end
    access(1'b1, 9'h010, 2'd2, 1'b0, 32'h0, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (rd !== 32'hDEAD55EF) begin errors++; $display("FAIL byte_write_merge got %h want %h", rd, 32'hDEAD55EF); end
  endtask

  task automatic test_errors;
    int lat, mocs; logic e; logic [31:0] rd; logic [8:0] bm;
    access(1'b1, 9'h013, 2'd0, 1'b0, 32'h0, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (rd !== 32'h000000EF) begin errors++; $display("FAIL err_pre_read got %h want %h", rd, 32'h000000EF); end
    access(1'b0, 9'h011, 2'd2, 1'b0, 32'h01020304, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (e !== 1'b1 || lat !== 3) begin errors++; $display("FAIL misaligned_write got err %b lat %0d want 1 3", e, lat); end
    access(1'b1, 9'h010, 2'd3, 1'b1, 32'h0, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (e !== 1'b1 || rd !== 32'h000000EF) begin errors++; $display("FAIL illegal_mode got err %b rdata %h want 1 %h", e, rd, 32'h000000EF); end
    access(1'b1, 9'h011, 2'd1, 1'b0, 32'h0, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (e !== 1'b1 || rd !== 32'h000000EF) begin errors++; $display("FAIL misaligned_half got err %b rdata %h want 1 %h", e, rd, 32'h000000EF); end
    access(1'b1, 9'h010, 2'd2, 1'b0, 32'h0, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (e !== 1'b0 || rd !== 32'hDEAD55EF) begin errors++; $display("FAIL err_post_read got err %b rdata %h want 0 %h", e, rd, 32'hDEAD55EF); end
  endtask

  task automatic test_reset_mid_op;
    int lat, mocs, seen; logic e; logic [31:0] rd; logic [8:0] bm;
    access(1'b0, 9'h020, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (e !== 1'b0 || mocs !== 1) begin errors++; $display("FAIL pre_write got err %b mocs %0d want 0 1", e, mocs); end
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 9'h020; mode = 2'd2; wdata = 32'h12345678;
    @(posedge clk); #1; req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || moc !== 1'b0 || rdata !== 32'h0)
      begin errors++; $display("FAIL mid_reset got busy %b moc %b rdata %h want 0 0 0", busy, moc, rdata); end
    @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (moc) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_moc got %0d want 0", seen); end
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 9'h020; mode = 2'd2; wdata = 32'h11223344;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (moc !== 1'b1) begin errors++; $display("FAIL done_moc got %b want 1", moc); end
    reset = 1'b1; #1;
    checks++; if (moc !== 1'b0) begin errors++; $display("FAIL done_reset_moc got %b want 0", moc); end
    @(posedge clk); #1; reset = 1'b0;
    access(1'b1, 9'h020, 2'd2, 1'b0, 32'h0, 1'b0, lat, e, rd, mocs, bm);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL aborted_writes got %h want %h", rd, 32'hCAFEF00D); end
  endtask

  task automatic test_busy_req;
    int lat, mocs; logic e; logic [31:0] rd; logic [8:0] bm;
    access(1'b1, 9'h022, 2'd1, 1'b1, 32'h0, 1'b1, lat, e, rd, mocs, bm);
    checks++; if (mocs !== 1 || lat !== 3) begin errors++; $display("FAIL busy_req got mocs %0d lat %0d want 1 3", mocs, lat); end
    checks++; if (rd !== 32'hFFFFF00D) begin errors++; $display("FAIL busy_req_data got %h want %h", rd, 32'hFFFFF00D); end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; mode = '0; sign_ext = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    test_reset;
    @(negedge clk); reset = 1'b0;
    test_word_rw;
    test_byte_half_reads;
    test_byte_write;
    test_errors;
    test_reset_mid_op;
    test_busy_req;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_mem_ctrl.md
Name: banked_mem_ctrl

Overview:
- Clocked, parametrised byte-lane memory controller. Stores memory as LANES independent LANE_W-bit banks and serves byte, halfword and word accesses over a req/moc handshake.
- Successor to the unclocked 4x128x8 access unit. Adds: parameterisable lane count, depth and wait states; a real FSM; sign/zero extension on loads; misalignment and illegal-mode error reporting.
- Sits between the CPU datapath memory interface (MAR/MDR, MOC) and the byte-lane RAM banks.

Parameters:
- LANES, 4, number of byte lanes; power of two, >= 2.
- LANE_W, 8, bits per lane.
- ADDR_W, 9, byte-address width; total capacity 2^ADDR_W lanes-units; each bank depth is 2^ADDR_W / LANES.
- WAIT_CYCLES, 2, ACCESS-state cycles before completion; >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  access request, sampled only in IDLE
- rw  in  1  1 = read, 0 = write
- addr  in  ADDR_W  byte address
- mode  in  2  access size = 2^mode lanes (0 byte, 1 half, 2 word)
- sign_ext  in  1  reads only: 1 sign-extends, 0 zero-extends
- wdata  in  LANES*LANE_W  write data, right-justified
- rdata  out  LANES*LANE_W  read data, extended
- moc  out  1  one-cycle completion pulse
- busy  out  1  high in ACCESS and DONE
- err  out  1  valid while moc=1; misaligned or illegal access

Behaviour:
- Reset: state=IDLE; rdata=0, moc=0, busy=0, err=0, wait counter=0. Bank contents are not cleared.
- Lane mapping is big-endian: byte at addr goes to lane addr % LANES, bank row addr / LANES. Word value = {lane0, lane1, ..., lane(LANES-1)}.
- Halfword at an aligned addr uses lanes (addr % LANES) and (addr % LANES)+1. The higher-numbered lane holds the low byte.
- Legality:
  - 2^mode > LANES is illegal.
  - addr % 2^mode != 0 is misaligned.
  - Either case gives err=1. Banks are untouched and rdata is unchanged.
- FSM:
  - IDLE: on req=1, latch addr, rw, mode, sign_ext and wdata. Set busy=1, counter=0, go to ACCESS.
  - ACCESS: counter increments each cycle. After WAIT_CYCLES cycles go to DONE.
  - DONE: moc=1 and err valid for exactly one cycle.
    - Legal write: commit the selected lanes at the DONE edge.
    - Legal read: update rdata at the DONE edge.
    - Then go to IDLE.
- Latency: req sampled at edge N; moc high during cycle N+WAIT_CYCLES+1. Back-to-back requests: the next req is accepted no earlier than the cycle after DONE.
- req while busy is ignored and not queued. Input changes after the latch edge have no effect.
- Read extension: result is the selected 2^mode lanes right-justified. The upper bits are filled with the result MSB when sign_ext=1, else with 0. A full-width word ignores sign_ext.
- Writes:
  - Only the selected lanes are written; unselected lanes keep their value.
  - wdata is taken from its low 2^mode*LANE_W bits.
- Reset mid-operation (ACCESS or DONE): return to IDLE. No write is committed, no moc is produced, rdata=0.
- Address wrap: none needed. Aligned accesses never cross a row.

Decomposition:
- Shared package: mode encodings (MODE_BYTE=0, MODE_HALF=1, MODE_WORD=2), FSM state enum (IDLE, ACCESS, DONE), and a log2(LANES) helper constant.
- One sub-module, lane_bank: synchronous single-port LANE_W x (2^ADDR_W/LANES) RAM with a per-lane write enable. Instantiate LANES copies in a generate loop.

Test Plan:
- Word write 0xDEADBEEF at 0x010, then word read at 0x010 -> rdata=0xDEADBEEF, err=0, moc exactly at cycle 3 after req (WAIT_CYCLES=2), busy high for cycles 1-3.
- Byte reads after the above: 0x011 sign_ext=1 -> 0xFFFFFFAD; 0x013 sign_ext=0 -> 0x000000EF.
- Halfword reads: 0x012 sign_ext=0 -> 0x0000BEEF; sign_ext=1 -> 0xFFFFBEEF; 0x010 sign_ext=0 -> 0x0000DEAD.
- Byte write 0x55 at 0x012, then word read 0x010 -> 0xDEAD55EF (other lanes intact).
- Word write at 0x011 and mode=3 read -> moc pulse with err=1; a follow-up word read at 0x010 is unchanged and rdata is unchanged.
- Word write 0x12345678 at 0x020 with reset asserted during ACCESS -> no moc; rdata=0; a subsequent read of 0x020 returns the prior contents. A req asserted while busy is ignored (exactly one moc per accepted req).
